frame_copy_engine: RTL and testbench



---
 rtl/frame_copy_engine_if.sv | 39 +++
 rtl/frame_copy_engine.sv | 123 ++++++++++++
 tb/tb_frame_copy_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_copy_engine_if.sv
// frame_copy_engine_if: control handshake plus source-read and display-write RAM ports.
// FRAME_COPY_FILL_EN adds the fill/fill_color screen-clear inputs.
interface frame_copy_engine_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [DATA_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [DATA_W-1:0] dst_data;
  logic              dst_wren;
  logic              busy;
  logic              done;
  logic              aborted;
`ifdef FRAME_COPY_FILL_EN
  logic              fill;
  logic [DATA_W-1:0] fill_color;

  modport master (
    input  start, abort, src_q, fill, fill_color,
    output src_rd_addr, dst_wr_addr, dst_data, dst_wren, busy, done, aborted
  );
  modport slave (
    output start, abort, src_q, fill, fill_color,
    input  src_rd_addr, dst_wr_addr, dst_data, dst_wren, busy, done, aborted
  );
`else
  modport master (
    input  start, abort, src_q,
    output src_rd_addr, dst_wr_addr, dst_data, dst_wren, busy, done, aborted
  );
  modport slave (
    output start, abort, src_q,
    input  src_rd_addr, dst_wr_addr, dst_data, dst_wren, busy, done, aborted
  );
`endif
endinterface

// File: rtl/frame_copy_engine.sv
// frame_copy_engine: streams a frame from working RAM to display RAM at one pixel per clock.
// Optional FRAME_COPY_FILL_EN replaces the copied data with a constant colour (screen clear).
module frame_copy_engine #(
  parameter int unsigned PIXELS = 76800,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  frame_copy_engine_if.master bus
);
  localparam int unsigned       AP_W      = RD_LAT * ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [RD_LAT-1:0] r_vpipe;
  logic [AP_W-1:0]   r_apipe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wren;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  logic              w_out_valid;
  logic [ADDR_W-1:0] w_out_addr;
  logic [DATA_W-1:0] w_out_data;
  logic              w_abort_active;

`ifdef FRAME_COPY_FILL_EN
  logic              r_fill;
  logic [DATA_W-1:0] r_fill_color;

  assign w_out_data = r_fill ? r_fill_color : bus.src_q;
`else
  assign w_out_data = bus.src_q;
`endif

  // Oldest pipe slot lines up with src_q for the address issued RD_LAT clocks earlier.
  assign w_out_valid    = r_vpipe[RD_LAT-1];
  assign w_out_addr     = r_apipe[AP_W-1 -: ADDR_W];
  assign w_abort_active = bus.abort && (r_state == READ || r_state == DRAIN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rd_addr    <= '0;
      r_vpipe      <= '0;
      r_apipe      <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wren       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
`ifdef FRAME_COPY_FILL_EN
      r_fill       <= 1'b0;
      r_fill_color <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_wren    <= 1'b0;
      r_vpipe   <= RD_LAT'({r_vpipe, (r_state == READ)});
      r_apipe   <= AP_W'({r_apipe, r_rd_addr});
      if (w_out_valid) begin
        r_wren    <= 1'b1;
        r_wr_addr <= w_out_addr;
        r_wr_data <= w_out_data;
      end

      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state   <= READ;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
`ifdef FRAME_COPY_FILL_EN
            r_fill       <= bus.fill;
            r_fill_color <= bus.fill_color;
`endif
          end
        end
        READ: begin
          if (r_rd_addr == LAST_ADDR) r_state <= DRAIN;
          else                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
        DRAIN: begin
          // Empty pipe here means the final write was registered on this same edge.
          if (r_vpipe == '0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_abort_active) begin
        r_state   <= IDLE;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_aborted <= 1'b1;
        r_wren    <= 1'b0;
        r_vpipe   <= '0;
      end
    end
  end

  assign bus.src_rd_addr = r_rd_addr;
  assign bus.dst_wr_addr = r_wr_addr;
  assign bus.dst_data    = r_wr_data;
  assign bus.dst_wren    = r_wren;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.aborted     = r_aborted;

endmodule

// File: tb/tb_frame_copy_engine.sv
// tb_frame_copy_engine: three engines (RD_LAT 1..3, PIXELS=8) on shared stimulus,
// each fed by a latency-matched source RAM model and checked against cycle formulas.
module tb_frame_copy_engine;
  localparam int P  = 8;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
`ifdef FRAME_COPY_FILL_EN
  logic          fill       = 1'b0;
  logic [DW-1:0] fill_color = '0;
`endif
  logic [DW-1:0] mem [16];

  logic [AW-1:0] o_rd   [N];
  logic [AW-1:0] o_wa   [N];
  logic [DW-1:0] o_wd   [N];
  logic          o_we   [N];
  logic          o_busy [N];
  logic          o_done [N];
  logic          o_ab   [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = g + 1;
    logic [DW-1:0] qp [L];
    frame_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();

    assign u_if.start = start;
    assign u_if.abort = abort;
    assign u_if.src_q = qp[L-1];
`ifdef FRAME_COPY_FILL_EN
    assign u_if.fill       = fill;
    assign u_if.fill_color = fill_color;
`endif

    always @(posedge clk) begin
      qp[0] <= mem[u_if.src_rd_addr];
      for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
    end

    frame_copy_engine #(.PIXELS(P), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (u_if.master)
    );

    assign o_rd[g]   = u_if.src_rd_addr;
    assign o_wa[g]   = u_if.dst_wr_addr;
    assign o_wd[g]   = u_if.dst_data;
    assign o_we[g]   = u_if.dst_wren;
    assign o_busy[g] = u_if.busy;
    assign o_done[g] = u_if.done;
    assign o_ab[g]   = u_if.aborted;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      total += 4;
      if (o_busy[g] !== 1'b0) begin bad++; $display("FAIL reset_busy lat=%0d got=%b exp=0", g+1, o_busy[g]); end
      if (o_we[g] !== 1'b0)   begin bad++; $display("FAIL reset_wren lat=%0d got=%b exp=0", g+1, o_we[g]); end
      if (o_done[g] !== 1'b0 || o_ab[g] !== 1'b0) begin
        bad++; $display("FAIL reset_pulses lat=%0d done=%b aborted=%b exp=0", g+1, o_done[g], o_ab[g]);
      end
      if (o_rd[g] !== '0 || o_wa[g] !== '0 || o_wd[g] !== '0) begin
        bad++; $display("FAIL reset_addr lat=%0d rd=%h wa=%h wd=%h exp=0", g+1, o_rd[g], o_wa[g], o_wd[g]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Copy scenario: abort_k=0 means no abort, otherwise abort is sampled at the end of cycle abort_k.
  task automatic test_copy(input string name, input bit fixed, input int abort_k,
                           input bit fill_en, input logic [DW-1:0] color);
    for (int a = 0; a < P; a++) mem[a] = fixed ? DW'(a + 16) : DW'($urandom);
`ifdef FRAME_COPY_FILL_EN
    fill       = fill_en;
    fill_color = color;
`endif
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= P + 7; c++) begin
      for (int g = 0; g < N; g++) begin
        int            L      = g + 1;
        logic          killed = (abort_k != 0) && (c > abort_k);
        logic          e_ab   = (abort_k != 0) && (c == abort_k + 1);
        logic          e_busy = !killed && c <= P + L + 1;
        logic          e_done = !killed && c == P + L + 2;
        logic          e_we   = !killed && c >= L + 2 && c <= P + L + 1;
        logic [AW-1:0] e_wa   = AW'(c - L - 2);
        logic [DW-1:0] e_wd   = fill_en ? color : mem[e_wa];
        total += 4;
        if (o_busy[g] !== e_busy) begin bad++; $display("FAIL %s_busy lat=%0d cyc=%0d got=%b exp=%b", name, L, c, o_busy[g], e_busy); end
        if (o_done[g] !== e_done) begin bad++; $display("FAIL %s_done lat=%0d cyc=%0d got=%b exp=%b", name, L, c, o_done[g], e_done); end
        if (o_ab[g] !== e_ab)     begin bad++; $display("FAIL %s_aborted lat=%0d cyc=%0d got=%b exp=%b", name, L, c, o_ab[g], e_ab); end
        if (o_we[g] !== e_we)     begin bad++; $display("FAIL %s_wren lat=%0d cyc=%0d got=%b exp=%b", name, L, c, o_we[g], e_we); end
        if (e_we) begin
          total += 2;
          if (o_wa[g] !== e_wa) begin bad++; $display("FAIL %s_waddr lat=%0d cyc=%0d got=%h exp=%h", name, L, c, o_wa[g], e_wa); end
          if (o_wd[g] !== e_wd) begin bad++; $display("FAIL %s_wdata lat=%0d cyc=%0d got=%h exp=%h", name, L, c, o_wd[g], e_wd); end
        end
        if (!killed && c <= P) begin
          total++;
          if (o_rd[g] !== AW'(c - 1)) begin bad++; $display("FAIL %s_raddr lat=%0d cyc=%0d got=%h exp=%h", name, L, c, o_rd[g], AW'(c - 1)); end
        end
      end
      abort = (abort_k != 0) && (c == abort_k);
      @(posedge clk);
      @(negedge clk);
    end
    abort = 1'b0;
`ifdef FRAME_COPY_FILL_EN
    fill = 1'b0;
`endif
  endtask

  task automatic test_start_held();
    int dcount [N];
    for (int g = 0; g < N; g++) dcount[g] = 0;
    for (int a = 0; a < P; a++) mem[a] = DW'($urandom);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= P + 7; c++) begin
      for (int g = 0; g < N; g++) begin
        int T = P + g + 3;
        if (c <= T + 1 && o_done[g] === 1'b1) dcount[g]++;
        if (c == T + 1) begin
          total++;
          if (o_busy[g] !== 1'b0) begin bad++; $display("FAIL held_idle_busy lat=%0d cyc=%0d got=%b exp=0", g+1, c, o_busy[g]); end
        end
        if (c == T + 2) begin
          total += 2;
          if (o_busy[g] !== 1'b1) begin bad++; $display("FAIL held_restart_busy lat=%0d cyc=%0d got=%b exp=1", g+1, c, o_busy[g]); end
          if (o_rd[g] !== '0)     begin bad++; $display("FAIL held_restart_raddr lat=%0d cyc=%0d got=%h exp=0", g+1, c, o_rd[g]); end
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    for (int g = 0; g < N; g++) begin
      total++;
      if (dcount[g] != 1) begin bad++; $display("FAIL held_done_count lat=%0d got=%0d exp=1", g+1, dcount[g]); end
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        total++;
        if (o_busy[g] !== 1'b0 || o_we[g] !== 1'b0 || o_done[g] !== 1'b0 || o_ab[g] !== 1'b0) begin
          bad++;
          $display("FAIL both_idle lat=%0d cyc=%0d busy=%b wren=%b done=%b aborted=%b exp=0",
                   g+1, c, o_busy[g], o_we[g], o_done[g], o_ab[g]);
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      total += 2;
      if (o_busy[g] !== 1'b0 || o_we[g] !== 1'b0 || o_done[g] !== 1'b0 || o_ab[g] !== 1'b0) begin
        bad++;
        $display("FAIL midrst_ctrl lat=%0d busy=%b wren=%b done=%b aborted=%b exp=0", g+1, o_busy[g], o_we[g], o_done[g], o_ab[g]);
      end
      if (o_rd[g] !== '0 || o_wa[g] !== '0 || o_wd[g] !== '0) begin
        bad++; $display("FAIL midrst_data lat=%0d rd=%h wa=%h wd=%h exp=0", g+1, o_rd[g], o_wa[g], o_wd[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        total++;
        if (o_we[g] !== 1'b0 || o_busy[g] !== 1'b0) begin
          bad++; $display("FAIL midrst_quiet lat=%0d cyc=%0d wren=%b busy=%b exp=0", g+1, c, o_we[g], o_busy[g]);
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = '0;
    @(negedge clk);
    test_reset();
    test_copy("copy_fixed", 1'b1, 0, 1'b0, '0);
    for (int r = 0; r < 3; r++) test_copy("copy_rand", 1'b0, 0, 1'b0, '0);
    test_start_held();
    test_copy("abort4", 1'b0, 4, 1'b0, '0);
    test_copy("abort9", 1'b0, 9, 1'b0, '0);
    test_copy("abort_rand", 1'b0, int'($urandom_range(1, 10)), 1'b0, '0);
    test_start_abort_idle();
    test_copy("copy_after_abort", 1'b0, 0, 1'b0, '0);
`ifdef FRAME_COPY_FILL_EN
    test_copy("fill_e0", 1'b0, 0, 1'b1, 8'hE0);
    test_copy("fill_rand", 1'b0, 0, 1'b1, DW'($urandom));
`endif
    test_reset_mid();
    test_copy("copy_after_reset", 1'b1, 0, 1'b0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
